// File: rtl/logic_pipe.sv
// Elastic DEPTH-stage pipeline computing y = op(a, b) and w = ~c.
// Bubbles collapse; flush drops in-flight beats.
module logic_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned MODE  = 0,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] w,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q, v_d, adv, up_v;
  logic [WIDTH-1:0] y_q [DEPTH];
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] op_y;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    case (MODE)
      1:       op_y = a | b;
      2:       op_y = a ^ b;
      default: op_y = a & b;
    endcase
  end

  // A stage may advance if anything downstream of it can make room.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~v_q[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~v_q[i];
    end
  end

  assign in_ready = adv[0] & ~flush;

  always_comb begin
    up_v    = '0;
    v_d     = '0;
    count_d = '0;
    up_v[0] = in_valid & in_ready;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_v[i] = v_q[i-1];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      v_d[i]  = adv[i] ? up_v[i] : v_q[i];
      count_d = count_d + CW'(v_d[i]);
    end
  end

  // Data moves only with a valid beat, so y/w hold whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        y_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (flush) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      if (adv[0] && up_v[0]) begin
        y_q[0] <= op_y;
        w_q[0] <= ~c;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i] && up_v[i]) begin
          y_q[i] <= y_q[i-1];
          w_q[i] <= w_q[i-1];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign y         = y_q[DEPTH-1];
  assign w         = w_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: DEPTH=3/MODE=0 and DEPTH=1/MODE=2 share one stimulus
// stream and are checked every cycle against a beat-list reference model.
module tb_logic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, flush, out_ready;
  logic [3:0] a, b, c;

  logic       ir0, ov0, ir1, ov1;
  logic [3:0] y0, w0, y1, w1;
  logic [1:0] cnt0;
  logic [0:0] cnt1;

  logic_pipe #(.WIDTH(4), .DEPTH(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .c(c),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .y(y0), .w(w0), .count(cnt0)
  );

  logic_pipe #(.WIDTH(4), .DEPTH(1), .MODE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .c(c),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .y(y1), .w(w1), .count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ordered list of beats (oldest first), each with its position.
  int         dep  [2] = '{3, 1};
  int         mode [2] = '{0, 2};
  int         msz  [2] = '{0, 0};
  int         mpos [2][4];
  logic [3:0] my   [2][4];
  logic [3:0] mw   [2][4];
  logic [3:0] moy  [2];
  logic [3:0] mow  [2];

  function automatic logic [3:0] ref_op(input int m, input logic [3:0] x, input logic [3:0] z);
    case (m)
      1:       return x | z;
      2:       return x ^ z;
      default: return x & z;
    endcase
  endfunction

  function automatic logic exp_ov(input int d);
    return (msz[d] > 0) && (mpos[d][0] == dep[d] - 1);
  endfunction

  // Room exists unless every slot is held and the output is stalled.
  function automatic logic exp_ir(input int d);
    return ((msz[d] < dep[d]) || out_ready) && !flush;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic ov, ir;
      int   limit, np;
      ov = exp_ov(d);
      ir = exp_ir(d);
      if (rst) begin
        msz[d] = 0;
        moy[d] = '0;
        mow[d] = '0;
      end else begin
        if (ov && out_ready) begin
          for (int i = 0; i < msz[d] - 1; i++) begin
            mpos[d][i] = mpos[d][i+1];
            my[d][i]   = my[d][i+1];
            mw[d][i]   = mw[d][i+1];
          end
          msz[d]--;
        end
        if (flush) begin
          msz[d] = 0;
        end else begin
          limit = dep[d] - 1;
          for (int i = 0; i < msz[d]; i++) begin
            np = (mpos[d][i] + 1 > limit) ? limit : mpos[d][i] + 1;
            mpos[d][i] = np;
            limit = np - 1;
          end
          if (in_valid && ir) begin
            mpos[d][msz[d]] = 0;
            my[d][msz[d]]   = ref_op(mode[d], a, b);
            mw[d][msz[d]]   = ~c;
            msz[d]++;
          end
          if (exp_ov(d)) begin
            moy[d] = my[d][0];
            mow[d] = mw[d][0];
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("ov0", 32'(ov0), 32'(exp_ov(0)));
    check_eq("y0", 32'(y0), 32'(moy[0]));
    check_eq("w0", 32'(w0), 32'(mow[0]));
    check_eq("cnt0", 32'(cnt0), 32'(msz[0]));
    check_eq("ir0", 32'(ir0), 32'(exp_ir(0)));
    check_eq("ov1", 32'(ov1), 32'(exp_ov(1)));
    check_eq("y1", 32'(y1), 32'(moy[1]));
    check_eq("w1", 32'(w1), 32'(mow[1]));
    check_eq("cnt1", 32'(cnt1), 32'(msz[1]));
    check_eq("ir1", 32'(ir1), 32'(exp_ir(1)));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    cyc();
    rst = 1'b0;
  endtask

  logic [3:0] got_y [8];
  int         ngot;
  logic       acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0;

    // Reset: two cycles, then idle state and ready.
    do_reset();
    check_eq("rst_ov", 32'(ov0), 0);
    check_eq("rst_y", 32'(y0), 0);
    check_eq("rst_w", 32'(w0), 0);
    check_eq("rst_cnt", 32'(cnt0), 0);
    #1;
    check_eq("rst_ir", 32'(ir0), 1);

    // Latency of DEPTH edges.
    a = 4'hC; b = 4'hA; c = 4'h3; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    check_eq("lat_early", 32'(ov0), 0);
    cyc();
    check_eq("lat_ov", 32'(ov0), 1);
    check_eq("lat_y", 32'(y0), 32'h8);
    check_eq("lat_w", 32'(w0), 32'hC);
    cyc();
    check_eq("lat_low", 32'(ov0), 0);
    check_eq("lat_hold", 32'(y0), 32'h8);

    // Backpressure: 3 of 4 accepted, then drained in order.
    out_ready = 1'b0; a = 4'hF; c = 4'h0;
    for (int j = 0; j < 4; j++) begin
      b = 4'(j + 1); in_valid = 1'b1;
      cyc();
    end
    check_eq("bp_cnt", 32'(cnt0), 3);
    check_eq("bp_ir", 32'(ir0), 0);
    out_ready = 1'b1;
    ngot = 0;
    for (int k = 0; k < 12; k++) begin
      acc = exp_ir(0);
      if (ov0 && out_ready && ngot < 8) begin
        got_y[ngot] = y0;
        ngot++;
      end
      cyc();
      if (acc) in_valid = 1'b0;
    end
    check_eq("bp_n", 32'(ngot), 4);
    for (int k = 0; k < 4; k++) check_eq("bp_order", 32'(got_y[k]), 32'(k + 1));
    check_eq("bp_empty", 32'(cnt0), 0);

    // Bubble collapse: second beat closes up behind a stalled first beat.
    do_reset();
    out_ready = 1'b1; a = 4'hF; b = 4'h5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (5) cyc();
    b = 4'h9; in_valid = 1'b1;
    check_eq("bub_ir", 32'(ir0), 1);
    cyc();
    in_valid = 1'b0;
    check_eq("bub_cnt", 32'(cnt0), 2);
    cyc();
    out_ready = 1'b1;
    check_eq("bub_y1", 32'(y0), 32'h5);
    cyc();
    check_eq("bub_ov2", 32'(ov0), 1);
    check_eq("bub_y2", 32'(y0), 32'h9);
    cyc();
    check_eq("bub_done", 32'(ov0), 0);

    // Flush a full pipe while a beat is offered.
    do_reset();
    out_ready = 1'b0; a = 4'hF;
    for (int j = 0; j < 3; j++) begin
      b = 4'(j + 1); in_valid = 1'b1;
      cyc();
    end
    flush = 1'b1; b = 4'h7;
    #1;
    check_eq("fl_ir", 32'(ir0), 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_cnt", 32'(cnt0), 0);
    check_eq("fl_ov", 32'(ov0), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_eq("fl_gone", 32'(ov0), 0);
    end

    // Reset together with flush mid-stream.
    out_ready = 1'b1; a = 4'hE; b = 4'h6; c = 4'h2; in_valid = 1'b1;
    repeat (3) cyc();
    rst = 1'b1; flush = 1'b1;
    cyc();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_eq("mr_ov", 32'(ov0), 0);
    check_eq("mr_y", 32'(y0), 0);
    check_eq("mr_w", 32'(w0), 0);
    check_eq("mr_cnt", 32'(cnt0), 0);

    // DEPTH=1, MODE=2 single-edge result.
    a = 4'h5; b = 4'h3; c = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_eq("d1_ov", 32'(ov1), 1);
    check_eq("d1_y", 32'(y1), 32'h6);
    check_eq("d1_w", 32'(w1), 32'hF);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      a         = 4'($urandom);
      b         = 4'($urandom);
      c         = 4'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
